// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder using a single full_adder cell.
// A start strobe in IDLE latches a, b and c_in; one bit pair is added per
// clock, LSB first, with a carry flop closing the loop. After WIDTH RUN
// cycles the parallel sum and carry-out are registered and done pulses once.
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous, active-high reset
//   start  - request, only honoured in IDLE
//   a, b   - WIDTH-bit operands, sampled with start
//   c_in   - carry-in, sampled with start
//   busy   - high while the serial add is running
//   done   - one-cycle pulse, result valid
//   sum    - registered sum, holds last result
//   c_out  - registered carry-out, holds last result

module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_fill;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    logic             last;

    full_adder fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .c_in (carry),
        .s    (fa_s),
        .c_out(fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // Sum register fills from the MSB; a 1-bit adder has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_fill1
            assign s_fill = fa_s;
        end else begin : g_filln
            assign s_fill = {fa_s, s_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_fill;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    // Final bit: publish the completed word including this bit.
                    if (last) begin
                        sum   <= s_fill;
                        c_out <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, c_in8, busy8, done8, c_out8;
    logic [7:0] a8, b8, sum8;
    logic       start1, c_in1, busy1, done1, c_out1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_sum  = 8'h00;
    logic       last_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(c_in8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation. Expected result comes from plain integer addition.
    // hold keeps start high through the run; chg alters operands mid-run.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input bit hold, input bit chg, input string tag);
        logic [8:0] exp;
        int cycles;
        exp = {1'b0, ta} + {1'b0, tb} + {8'h00, tc};
        start8 = 1'b1; a8 = ta; b8 = tb; c_in8 = tc;
        tick();
        if (!hold) start8 = 1'b0;
        cycles = 0;
        while (busy8 && cycles < 20) begin
            chk({tag, "_hold_sum"}, {23'b0, last_cout, last_sum}, {23'b0, c_out8, sum8});
            chk({tag, "_nodone_run"}, {31'b0, done8}, 32'd0);
            if (chg && cycles == 3) begin
                a8 = ~ta; b8 = ~tb; c_in8 = ~tc;
            end
            tick();
            cycles++;
        end
        chk({tag, "_busy_cycles"}, cycles, 32'd8);
        chk({tag, "_done"}, {31'b0, done8}, 32'd1);
        chk({tag, "_result"}, {23'b0, c_out8, sum8}, {23'b0, exp});
        last_sum = exp[7:0]; last_cout = exp[8];
        tick();
        chk({tag, "_done_pulse"}, {30'b0, done8, busy8}, 32'd0);
        start8 = 1'b0;
        tick();
        chk({tag, "_idle_after"}, {30'b0, done8, busy8}, 32'd0);
        chk({tag, "_result_held"}, {23'b0, c_out8, sum8}, {23'b0, exp});
    endtask

    initial begin
        logic [1:0] exp1;
        int cyc;
        rst = 1'b1;
        start8 = 0; a8 = 0; b8 = 0; c_in8 = 0;
        start1 = 0; a1 = 0; b1 = 0; c_in1 = 0;
        tick(); tick();
        chk("reset8", {21'b0, busy8, done8, c_out8, sum8}, 32'd0);
        chk("reset1", {28'b0, busy1, done1, c_out1, sum1}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle8", {21'b0, busy8, done8, c_out8, sum8}, 32'd0);

        op8(8'h35, 8'h0A, 1'b0, 0, 0, "t1");
        op8(8'hFF, 8'h01, 1'b0, 0, 0, "t2a");
        op8(8'hFF, 8'h00, 1'b1, 0, 0, "t2b");
        op8(8'hFF, 8'hFF, 1'b1, 0, 0, "t3a");
        op8(8'h00, 8'h00, 1'b0, 0, 0, "t3b");
        op8(8'h11, 8'h22, 1'b0, 1, 1, "t4");

        // Reset during the 4th RUN cycle: everything clears, no done later.
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; c_in8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        chk("t5_busy_before", {31'b0, busy8}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_abort", {21'b0, busy8, done8, c_out8, sum8}, 32'd0);
        last_sum = 8'h00; last_cout = 1'b0;
        cyc = 0;
        repeat (12) begin
            tick();
            if (done8 || busy8) cyc++;
        end
        chk("t5_no_done_after", cyc, 32'd0);

        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, 0, "rnd");

        // WIDTH=1 instance: full truth table.
        for (int k = 0; k < 8; k++) begin
            a1 = k[2]; b1 = k[1]; c_in1 = k[0];
            exp1 = 2'(k[2]) + 2'(k[1]) + 2'(k[0]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("t6_busy", {30'b0, busy1, done1}, 32'd2);
            tick();
            chk("t6_done", {30'b0, busy1, done1}, 32'd1);
            chk("t6_result", {30'b0, c_out1, sum1}, {30'b0, exp1});
            tick();
            chk("t6_pulse", {30'b0, busy1, done1}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
